dmem_port_arbiter: RTL
======================

Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage (requester CPU) and the seven-segment memory viewer (requester DBG).
- Sits between the MEM stage and data_mem; drives the data_mem A/inD/sel/str pins.
- CPU has priority, with a bounded-starvation guarantee for DBG; stalls the pipeline only when DBG is forced in.
- data_mem reads are combinational; writes commit on the clk_dvid edge.

Parameters:
ADDR_W, 10, word-address width (data_mem A).
DATA_W, 32, data width.
STARVE_MAX, 4, max consecutive CPU-granted cycles while DBG waits before DBG is forced in (legal range 1..15).

Ports:
clk_dvid  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
cpu_req  input  1  MEM stage needs memory this cycle (load or store).
cpu_we  input  1  store when 1.
cpu_sel  input  4  byte enables, passed to data_mem sel.
cpu_addr  input  ADDR_W  word address.
cpu_wdata  input  DATA_W  store data.
cpu_rdata  output  DATA_W  load data (combinational from mem_outD).
cpu_stall  output  1  CPU denied this cycle; freeze PC, IF/ID, ID/EX, EX/MEM, and bubble MEM/WB.
dbg_req  input  1  viewer read request; held high until dbg_ack.
dbg_addr  input  ADDR_W  viewer word address; stable while dbg_req is high.
dbg_ack  output  1  one-cycle pulse; dbg_rdata valid from this cycle.
dbg_rdata  output  DATA_W  registered read data; holds until next ack.
mem_A  output  ADDR_W  to data_mem A.
mem_inD  output  DATA_W  to data_mem inD.
mem_sel  output  4  to data_mem sel.
mem_str  output  1  to data_mem str.
mem_outD  input  DATA_W  from data_mem outD.
owner  output  2  debug: 00 none, 01 CPU, 10 DBG.

Behaviour:
- DBG FSM states are D_IDLE, D_WAIT, D_GRANT, D_ACK, all registered.
  - D_IDLE: if dbg_req then D_WAIT.
  - D_WAIT: grant DBG this cycle if (!cpu_req) or (starve_cnt == STARVE_MAX); on grant go to D_GRANT, otherwise stay.
  - D_GRANT: one cycle after the grant cycle; dbg_rdata was captured at the grant edge. Go to D_ACK.
  - D_ACK: dbg_ack=1 for exactly this cycle. Go to D_IDLE; a new request is accepted on the following cycle at the earliest.
- Port mux (combinational):
  - DBG granted: mem_A=dbg_addr, mem_str=0, mem_sel=4'b1111, owner=10, cpu_stall=cpu_req.
  - Otherwise, if cpu_req: mem_A=cpu_addr, mem_inD=cpu_wdata, mem_sel=cpu_sel, mem_str=cpu_we, owner=01.
  - Otherwise: mem_str=0, owner=00.
- cpu_stall is never asserted when DBG is not granted. A stalled CPU access replays unchanged on the next cycle, and that cycle is always granted to CPU.
- starve_cnt (4-bit register):
  - Cleared on a DBG grant and whenever the FSM is not in D_WAIT.
  - Increments each D_WAIT cycle in which CPU is granted; saturates at STARVE_MAX.
- dbg_rdata is registered from mem_outD on the grant edge.
- A store by CPU in the cycle immediately before a DBG read of the same address is visible to DBG, because the write commits first.
- Reset (asserted, reset=0), asynchronous:
  - FSM to D_IDLE, starve_cnt=0, dbg_rdata=0, dbg_ack=0.
  - Combinational outputs with no requests: cpu_stall=0, mem_str=0, owner=00.
  - Reset mid-D_GRANT drops the pending ack.
- Simultaneous cpu_req and dbg_req from D_IDLE: CPU is served, and DBG enters D_WAIT the next cycle.
- Worst-case DBG latency from dbg_req to dbg_ack is STARVE_MAX+3 cycles.
- cpu_rdata = mem_outD always; it is valid only when CPU is granted.

Optional Feature:
DMEM_ARB_STATS_EN:
- When defined: adds outputs stall_cycles[31:0] and dbg_grants[31:0].
  - Both are free-running, wrap at 2^32, and are cleared by reset.
  - stall_cycles increments on every cycle with cpu_stall=1; dbg_grants increments per DBG grant.
  - Intended for display_change selection.
- When undefined: the ports still exist, are tied to 0, and no counters are synthesised.

Test Plan:
- Reset low during DBG D_WAIT, then release -> owner=00, dbg_ack=0, dbg_rdata=0; no write issued.
- dbg_req, addr=0x005, cpu_req=0, mem[5]=0xDEADBEEF -> grant in cycle 1, dbg_ack in cycle 3, dbg_rdata=0xDEADBEEF, cpu_stall never 1.
- cpu_req held continuously, dbg_req at t0, STARVE_MAX=4 -> CPU granted 4 cycles, DBG granted and cpu_stall=1 in cycle 5 only, CPU granted cycle 6, dbg_ack cycle 7.
- CPU store 0x12345678 to addr 0x010, then next cycle DBG granted on addr 0x010 -> dbg_rdata=0x12345678.
- cpu_req and dbg_req rise together from idle, cpu_req low afterwards -> CPU served first; DBG granted the next cycle; exactly one dbg_ack.
- With DMEM_ARB_STATS_EN, run the forced-grant scenario 3 times -> stall_cycles=3, dbg_grants=3; without the macro, both read 0.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single-port data memory between the pipeline
// MEM stage (CPU) and the seven-segment memory viewer (DBG).
// The CPU normally wins.  A waiting DBG request is forced in after STARVE_MAX
// consecutive CPU-granted cycles, and the CPU is stalled only in that cycle.
// data_mem reads are combinational.  Writes commit on the clk_dvid edge.
// Optional build macro DMEM_ARB_STATS_EN enables the stall_cycles and
// dbg_grants counters.  When it is undefined, both ports are tied to zero.
module dmem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_dvid,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [3:0]        cpu_sel,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_inD,
  output logic [3:0]        mem_sel,
  output logic              mem_str,
  input  logic [DATA_W-1:0] mem_outD,
  output logic [1:0]        owner,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       dbg_grants
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_WAIT  = 2'd1,
    D_GRANT = 2'd2,
    D_ACK   = 2'd3
  } dbg_state_t;

  dbg_state_t        state_reg;
  dbg_state_t        state_next;
  logic [3:0]        starve_cnt_reg;
  logic [DATA_W-1:0] dbg_rdata_reg;
  logic              dbg_grant;

  // DBG owns the port while waiting if the CPU is idle or has used up its
  // starvation budget.
  assign dbg_grant = (state_reg == D_WAIT) &&
                     (!cpu_req || (starve_cnt_reg == STARVE_LIM));

  // The CPU sees whatever data_mem drives.  It is only meaningful when the
  // CPU holds the port.
  assign cpu_rdata = mem_outD;
  assign dbg_rdata = dbg_rdata_reg;

  // FSM state register
  always_ff @(posedge clk_dvid or negedge reset) begin
    if (!reset) begin
      state_reg <= D_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state: request -> wait -> grant -> ack -> idle
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      D_IDLE:  if (dbg_req) state_next = D_WAIT;
      D_WAIT:  if (dbg_grant) state_next = D_GRANT;
      D_GRANT: state_next = D_ACK;
      D_ACK:   state_next = D_IDLE;
      default: state_next = D_IDLE;
    endcase
  end

  // FSM outputs and memory port mux (DBG grant overrides the CPU)
  always_comb begin
    mem_A     = cpu_addr;
    mem_inD   = cpu_wdata;
    mem_sel   = 4'b0000;
    mem_str   = 1'b0;
    owner     = 2'b00;
    cpu_stall = 1'b0;
    dbg_ack   = (state_reg == D_ACK);
    if (dbg_grant) begin
      mem_A     = dbg_addr;
      mem_sel   = 4'b1111;
      owner     = 2'b10;
      cpu_stall = cpu_req;
    end else if (cpu_req) begin
      mem_sel   = cpu_sel;
      mem_str   = cpu_we;
      owner     = 2'b01;
    end
  end

  // Count CPU wins while DBG waits.  The count saturates at the limit and
  // clears outside D_WAIT or on a grant.
  always_ff @(posedge clk_dvid or negedge reset) begin
    if (!reset) begin
      starve_cnt_reg <= 4'd0;
    end else if ((state_reg != D_WAIT) || dbg_grant) begin
      starve_cnt_reg <= 4'd0;
    end else if (cpu_req && (starve_cnt_reg != STARVE_LIM)) begin
      starve_cnt_reg <= starve_cnt_reg + 4'd1;
    end
  end

  // Capture the viewer's word on the grant edge.  It holds until the next
  // grant.
  always_ff @(posedge clk_dvid or negedge reset) begin
    if (!reset) begin
      dbg_rdata_reg <= '0;
    end else if (dbg_grant) begin
      dbg_rdata_reg <= mem_outD;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stall_cycles_reg;
  logic [31:0] dbg_grants_reg;

  // Free-running statistics that wrap naturally at 2^32
  always_ff @(posedge clk_dvid or negedge reset) begin
    if (!reset) begin
      stall_cycles_reg <= 32'd0;
      dbg_grants_reg   <= 32'd0;
    end else begin
      if (cpu_stall) stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if (dbg_grant) dbg_grants_reg   <= dbg_grants_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign dbg_grants   = dbg_grants_reg;
`else
  assign stall_cycles = 32'd0;
  assign dbg_grants   = 32'd0;
`endif

endmodule
